cl_gen: RTL and testbench
=========================

CL_GEN -- requirements
Module: cl_gen

Interface
REQ-001 SHALL have parameter N_FRAME_SIZE, default 20, width of the frame count field in the start command.
REQ-002 SHALL have parameter H_GAP, default 4, bus_clk cycles with cl_lval low between lines.
REQ-003 SHALL have parameter V_GAP, default 16, bus_clk cycles with cl_fval low between frames.
REQ-004 SHALL have port bus_clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pc_msg_pending, input, 1, a command word is waiting.
REQ-007 SHALL have port pc_msg, input, 32, command word: [31:20] opcode, [19:0] argument.
REQ-008 SHALL have port pc_msg_ack, output, 1, one-cycle consume pulse.
REQ-009 SHALL have port cl_fval, output, 1, frame valid.
REQ-010 SHALL have port cl_lval, output, 1, line valid.
REQ-011 SHALL have ports cl_port_a..cl_port_j, output, 8 each, Camera Link pixel bytes, index k = 0 (a) .. 9 (j).
REQ-012 SHALL have port gen_done, output, 1, one-cycle pulse when a frame burst completes.

Function
REQ-013 SHALL ack a message when pc_msg_pending && !pc_msg_ack; pc_msg_ack is registered, high one cycle, at most once per message.
REQ-014 SHALL decode opcodes: 'h2 sets n_lines = arg[11:0]; 'h3 sets n_clks = arg[9:0]; 'h1 starts a burst of arg[N_FRAME_SIZE-1:0] frames; 'hF aborts; any other opcode is acked and ignored.
REQ-015 SHALL accept opcodes 'h1/'h2/'h3 only in IDLE; outside IDLE they are acked and dropped.
REQ-016 SHALL treat n_lines = 0 or n_clks = 0 as 1.
REQ-017 SHALL implement states IDLE, FSTART, LINE, HGAP, FEND, VGAP.
REQ-018 SHALL, on start with count 0, stay in IDLE and pulse gen_done the cycle after the ack.
REQ-019 SHALL, on start with count N > 0, enter FSTART in the cycle after the ack; FSTART lasts 1 cycle with cl_fval high and cl_lval low.
REQ-020 SHALL drive cl_lval high for exactly n_clks consecutive cycles in LINE, then H_GAP cycles low in HGAP, for n_lines lines; there is no HGAP after the last line.
REQ-021 SHALL hold cl_fval high from FSTART through the last LINE cycle plus one FEND cycle, then hold cl_fval low for V_GAP cycles in VGAP.
REQ-022 SHALL decrement the remaining frame count at the end of FEND; after VGAP, go to FSTART if the count is nonzero, else go to IDLE and pulse gen_done.
REQ-023 SHALL drive cl_port_k = pix[7:0] + k (modulo 256) while cl_lval is high, where pix is 0 on the first clock of each line and increments each LINE cycle; all ports are 0 when cl_lval is low.
REQ-024 SHALL keep a 12-bit line index (0 at FSTART, +1 per line) and a 12-bit frame index (0 at start, +1 per frame), both wrapping.
REQ-025 SHALL, on abort in any non-IDLE state, drive cl_fval, cl_lval and all ports low on the next cycle, enter IDLE, clear the frame count, and not pulse gen_done; abort in IDLE is acked only.
REQ-026 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while reset_n is low, force state IDLE, cl_fval = cl_lval = 0, all ports = 0, pc_msg_ack = 0, gen_done = 0, n_lines = 1, n_clks = 1, and all counters = 0, including in the middle of a frame.
REQ-028 SHALL begin operating on the first bus_clk edge after reset_n rises.

Configuration
REQ-029 SHALL, with CL_GEN_HEADER_EN defined, override pix = 0 of every line with cl_port_a = frame[7:0], cl_port_b = line[7:0], cl_port_c = {frame[11:8], line[11:8]}; ports d..j keep the pattern.
REQ-030 SHALL, with CL_GEN_HEADER_EN undefined, apply the REQ-023 pattern on every pixel, including pixel 0.

Verification
REQ-031 SHALL cover: 'h2 arg 3, 'h3 arg 8, 'h1 arg 1 -> three 8-cycle lval pulses separated by 4 low cycles; fval high 1 + 32 + 1 = 34 cycles; one gen_done after VGAP.
REQ-032 SHALL cover: 'h1 arg 0 -> ack, gen_done the next cycle, fval never rises.
REQ-033 SHALL cover: 'h3 arg 300 -> port_a wraps 255 -> 0 at pix 256; port_j = 9 at pix 0 (header disabled).
REQ-034 SHALL cover: 'hF during the 2nd line of frame 2 of a 5-frame burst -> fval/lval low next cycle, IDLE, no gen_done; a following 'h1 runs normally.
REQ-035 SHALL cover: reset_n pulsed low mid-LINE -> all outputs 0 asynchronously; n_lines and n_clks return to 1.
REQ-036 SHALL cover: with CL_GEN_HEADER_EN, 2 frames of 2 lines -> pixel 0 of frame 1, line 1 shows a = 1, b = 1, c = 0.

Source files
------------

// File: rtl/cl_gen.sv
// cl_gen: Camera Link test-pattern generator driven by 32-bit host command words.
//   Command word: [31:20] opcode, [19:0] argument.
//     'h1 start a burst of arg[N_FRAME_SIZE-1:0] frames
//     'h2 set lines per frame   (arg[11:0], 0 is treated as 1)
//     'h3 set clocks per line   (arg[9:0],  0 is treated as 1)
//     'hF abort a running burst
//   Pixel byte k of a line is (pix + k) mod 256, pix counting from 0 each line.
//   Optional macro CL_GEN_HEADER_EN: pixel 0 of each line carries frame/line
//   indices on ports a..c instead of the pattern.
//   H_GAP and V_GAP must be at least 1.
//   All outputs are registered; they reflect the state entered on each edge.
module cl_gen #(
   parameter int N_FRAME_SIZE = 20,
   parameter int H_GAP        = 4,
   parameter int V_GAP        = 16
) (
   input  logic        bus_clk,
   input  logic        reset_n,
   input  logic        pc_msg_pending,
   input  logic [31:0] pc_msg,
   output logic        pc_msg_ack,
   output logic        cl_fval,
   output logic        cl_lval,
   output logic [7:0]  cl_port_a,
   output logic [7:0]  cl_port_b,
   output logic [7:0]  cl_port_c,
   output logic [7:0]  cl_port_d,
   output logic [7:0]  cl_port_e,
   output logic [7:0]  cl_port_f,
   output logic [7:0]  cl_port_g,
   output logic [7:0]  cl_port_h,
   output logic [7:0]  cl_port_i,
   output logic [7:0]  cl_port_j,
   output logic        gen_done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FSTART = 3'd1,
      LINE   = 3'd2,
      HGAP   = 3'd3,
      FEND   = 3'd4,
      VGAP   = 3'd5
   } state_t;

   localparam logic [15:0] H_LAST = 16'(H_GAP - 1);
   localparam logic [15:0] V_LAST = 16'(V_GAP - 1);

   localparam logic [11:0] OP_START = 12'h001;
   localparam logic [11:0] OP_LINES = 12'h002;
   localparam logic [11:0] OP_CLKS  = 12'h003;
   localparam logic [11:0] OP_ABORT = 12'h00F;

   // registered state
   state_t                    state, state_next;
   logic [31:0]               msg, msg_next;
   logic                      ack, ack_next;
   logic [11:0]               n_lines, n_lines_next;
   logic [9:0]                n_clks, n_clks_next;
   logic [N_FRAME_SIZE-1:0]   frames_left, frames_left_next;
   logic [9:0]                pix, pix_next;
   logic [11:0]               line_idx, line_next;
   logic [11:0]               frame_idx, frame_next;
   logic [15:0]               gap_cnt, gap_next;

   // registered outputs and their next values
   logic                      fval, fval_next;
   logic                      lval, lval_next;
   logic                      done, done_next;
   logic [7:0]                port_reg  [10];
   logic [7:0]                port_next [10];

   // command decode helpers
   logic [11:0]               op;
   logic [19:0]               arg;
   logic [N_FRAME_SIZE-1:0]   start_count;
   logic [11:0]               lines_eff;
   logic [9:0]                clks_eff;

   assign op          = msg[31:20];
   assign arg         = msg[19:0];
   assign start_count = arg[N_FRAME_SIZE-1:0];
   assign lines_eff   = (n_lines == 12'd0) ? 12'd1 : n_lines;
   assign clks_eff    = (n_clks  == 10'd0) ? 10'd1 : n_clks;

   // Ack handshake: consume one waiting word, capturing it for decode next cycle.
   always_comb begin
      ack_next = pc_msg_pending && !ack;
      msg_next = ack_next ? pc_msg : msg;
   end

   // State register and all counters / configuration.
   always_ff @(posedge bus_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         msg         <= '0;
         ack         <= 1'b0;
         n_lines     <= 12'd1;
         n_clks      <= 10'd1;
         frames_left <= '0;
         pix         <= '0;
         line_idx    <= '0;
         frame_idx   <= '0;
         gap_cnt     <= '0;
      end else begin
         state       <= state_next;
         msg         <= msg_next;
         ack         <= ack_next;
         n_lines     <= n_lines_next;
         n_clks      <= n_clks_next;
         frames_left <= frames_left_next;
         pix         <= pix_next;
         line_idx    <= line_next;
         frame_idx   <= frame_next;
         gap_cnt     <= gap_next;
      end
   end

   // Next-state logic: command decode in IDLE, frame/line sequencing elsewhere.
   always_comb begin
      state_next       = state;
      n_lines_next     = n_lines;
      n_clks_next      = n_clks;
      frames_left_next = frames_left;
      pix_next         = pix;
      line_next        = line_idx;
      frame_next       = frame_idx;
      gap_next         = gap_cnt;
      done_next        = 1'b0;

      case (state)
         IDLE: begin
            if (ack) begin
               case (op)
                  OP_LINES: n_lines_next = arg[11:0];
                  OP_CLKS:  n_clks_next  = arg[9:0];
                  OP_START: begin
                     if (start_count == '0) begin
                        done_next = 1'b1;
                     end else begin
                        state_next       = FSTART;
                        frames_left_next = start_count;
                        frame_next       = 12'd0;
                        line_next        = 12'd0;
                     end
                  end
                  default: ;
               endcase
            end
         end
         FSTART: begin
            state_next = LINE;
            pix_next   = 10'd0;
            line_next  = 12'd0;
         end
         LINE: begin
            if (pix == clks_eff - 10'd1) begin
               gap_next = 16'd0;
               if (line_idx == lines_eff - 12'd1) begin
                  state_next = FEND;
               end else begin
                  state_next = HGAP;
               end
            end else begin
               pix_next = pix + 10'd1;
            end
         end
         HGAP: begin
            if (gap_cnt == H_LAST) begin
               state_next = LINE;
               pix_next   = 10'd0;
               line_next  = line_idx + 12'd1;
            end else begin
               gap_next = gap_cnt + 16'd1;
            end
         end
         FEND: begin
            state_next       = VGAP;
            gap_next         = 16'd0;
            frames_left_next = frames_left - N_FRAME_SIZE'(1);
         end
         VGAP: begin
            if (gap_cnt == V_LAST) begin
               if (frames_left != '0) begin
                  state_next = FSTART;
                  frame_next = frame_idx + 12'd1;
                  line_next  = 12'd0;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end else begin
               gap_next = gap_cnt + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Abort wins over everything else outside IDLE and suppresses gen_done.
      if (ack && (op == OP_ABORT) && (state != IDLE)) begin
         state_next       = IDLE;
         frames_left_next = '0;
         done_next        = 1'b0;
      end
   end

   // Output decode from the state being entered, so outputs register in step with it.
   always_comb begin
      fval_next = (state_next == FSTART) || (state_next == LINE) ||
                  (state_next == HGAP)   || (state_next == FEND);
      lval_next = (state_next == LINE);
   end

   // Per-port pixel byte: pattern while lval is high, zero otherwise.
   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_port
         logic [7:0] pattern;
         assign pattern = pix_next[7:0] + 8'(gi);
`ifdef CL_GEN_HEADER_EN
         if (gi < 3) begin : g_hdr
            logic [7:0] header;
            if (gi == 0) begin : g_a
               assign header = frame_next[7:0];
            end else if (gi == 1) begin : g_b
               assign header = line_next[7:0];
            end else begin : g_c
               assign header = {frame_next[11:8], line_next[11:8]};
            end
            assign port_next[gi] = !lval_next           ? 8'd0   :
                                   (pix_next == 10'd0)  ? header : pattern;
         end else begin : g_plain
            assign port_next[gi] = lval_next ? pattern : 8'd0;
         end
`else
         assign port_next[gi] = lval_next ? pattern : 8'd0;
`endif
      end
   endgenerate

   // Output registers.
   always_ff @(posedge bus_clk or negedge reset_n) begin
      if (!reset_n) begin
         fval <= 1'b0;
         lval <= 1'b0;
         done <= 1'b0;
         for (int k = 0; k < 10; k++) begin
            port_reg[k] <= 8'd0;
         end
      end else begin
         fval <= fval_next;
         lval <= lval_next;
         done <= done_next;
         for (int k = 0; k < 10; k++) begin
            port_reg[k] <= port_next[k];
         end
      end
   end

   assign pc_msg_ack = ack;
   assign cl_fval    = fval;
   assign cl_lval    = lval;
   assign gen_done   = done;
   assign cl_port_a  = port_reg[0];
   assign cl_port_b  = port_reg[1];
   assign cl_port_c  = port_reg[2];
   assign cl_port_d  = port_reg[3];
   assign cl_port_e  = port_reg[4];
   assign cl_port_f  = port_reg[5];
   assign cl_port_g  = port_reg[6];
   assign cl_port_h  = port_reg[7];
   assign cl_port_i  = port_reg[8];
   assign cl_port_j  = port_reg[9];

endmodule

// File: tb/tb_cl_gen.sv
// tb_cl_gen: directed test of cl_gen against a frame-level output model.
//   Every acked command is fed to a model that expands a start command into
//   the full per-cycle list of expected outputs; one compare process checks
//   the DUT against that list every cycle. Literal checks pin the model.
//   Honours CL_GEN_HEADER_EN the same way the design does.
module tb_cl_gen;

   localparam int NF = 20;
   localparam int HG = 4;
   localparam int VG = 16;

   logic        bus_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pc_msg_pending = 1'b0;
   logic [31:0] pc_msg = '0;
   logic        pc_msg_ack, cl_fval, cl_lval, gen_done;
   logic [7:0]  cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e;
   logic [7:0]  cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j;

   cl_gen #(.N_FRAME_SIZE(NF), .H_GAP(HG), .V_GAP(VG)) dut (
      .bus_clk(bus_clk), .reset_n(reset_n),
      .pc_msg_pending(pc_msg_pending), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
      .cl_fval(cl_fval), .cl_lval(cl_lval),
      .cl_port_a(cl_port_a), .cl_port_b(cl_port_b), .cl_port_c(cl_port_c),
      .cl_port_d(cl_port_d), .cl_port_e(cl_port_e), .cl_port_f(cl_port_f),
      .cl_port_g(cl_port_g), .cl_port_h(cl_port_h), .cl_port_i(cl_port_i),
      .cl_port_j(cl_port_j), .gen_done(gen_done)
   );

   always #5 bus_clk = ~bus_clk;

   typedef struct packed {
      logic            fval;
      logic            lval;
      logic            gd;
      logic [9:0][7:0] px;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cur_msg  = '0;
   exp_t        exp_q[$];
   int          m_nl = 1;
   int          m_nc = 1;

   // observation counters, written only by the compare process
   int fval_hi = 0, lval_hi = 0, lval_rise = 0, fval_rise = 0, gd_cnt = 0;
   int line_in_frame = 0, dut_pix = 0;
   logic prev_lval = 1'b0, prev_fval = 1'b0;
   logic [7:0] cap_a [512];
   logic [7:0] cap_j [512];
   logic [7:0] hdr_a [8][8];
   logic [7:0] hdr_b [8][8];
   logic [7:0] hdr_c [8][8];

   task automatic chk(input string name, input int got, input int need);
      n_checks++;
      if (got != need) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, need, $time);
      end
   endtask

   // Expand a burst of frames into expected per-cycle outputs.
   task automatic push_burst(input int frames);
      exp_t e;
      for (int f = 0; f < frames; f++) begin
         e = '0; e.fval = 1'b1;
         exp_q.push_back(e);                              // frame start
         for (int l = 0; l < m_nl; l++) begin
            for (int p = 0; p < m_nc; p++) begin
               e = '0; e.fval = 1'b1; e.lval = 1'b1;
               for (int k = 0; k < 10; k++) e.px[k] = 8'((p + k) % 256);
`ifdef CL_GEN_HEADER_EN
               if (p == 0) begin
                  e.px[0] = 8'(f % 256);
                  e.px[1] = 8'(l % 256);
                  e.px[2] = 8'((((f / 256) % 16) * 16) + ((l / 256) % 16));
               end
`endif
               exp_q.push_back(e);
            end
            if (l < m_nl - 1) begin
               for (int g = 0; g < HG; g++) begin
                  e = '0; e.fval = 1'b1;
                  exp_q.push_back(e);
               end
            end
         end
         e = '0; e.fval = 1'b1;
         exp_q.push_back(e);                              // frame end
         for (int g = 0; g < VG; g++) exp_q.push_back('0);
      end
      e = '0; e.gd = 1'b1;
      exp_q.push_back(e);
   endtask

   // Apply one acked command to the model.
   task automatic model_msg(input logic [31:0] m);
      logic [11:0] op;
      int          arg;
      bit          idle;
      exp_t        e;
      op   = m[31:20];
      arg  = int'(m[19:0]);
      idle = (exp_q.size() == 0);
      case (op)
         12'h002: if (idle) m_nl = ((arg % 4096) == 0) ? 1 : (arg % 4096);
         12'h003: if (idle) m_nc = ((arg % 1024) == 0) ? 1 : (arg % 1024);
         12'h001: if (idle) begin
            if (arg == 0) begin
               e = '0; e.gd = 1'b1;
               exp_q.push_back(e);
            end else begin
               push_burst(arg);
            end
         end
         12'h00F: exp_q.delete();
         default: ;
      endcase
   endtask

   // Compare process: one check per cycle, then feed any ack to the model.
   always @(negedge bus_clk) begin : compare
      exp_t e;
      exp_t o;
      if (!reset_n) begin
         exp_q.delete();
         m_nl = 1;
         m_nc = 1;
      end else begin
         e = '0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         o.fval = cl_fval; o.lval = cl_lval; o.gd = gen_done;
         o.px = {cl_port_j, cl_port_i, cl_port_h, cl_port_g, cl_port_f,
                 cl_port_e, cl_port_d, cl_port_c, cl_port_b, cl_port_a};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            if (n_fail <= 30)
               $display("FAIL cycle t=%0t got fval=%b lval=%b gd=%b px=%h, expected fval=%b lval=%b gd=%b px=%h",
                        $time, o.fval, o.lval, o.gd, o.px, e.fval, e.lval, e.gd, e.px);
         end
         if (cl_fval) fval_hi++;
         if (cl_lval) lval_hi++;
         if (gen_done) gd_cnt++;
         if (cl_fval && !prev_fval) begin
            fval_rise++;
            line_in_frame = 0;
         end
         if (cl_lval && !prev_lval) begin
            lval_rise++;
            dut_pix = 0;
            hdr_a[fval_rise % 8][line_in_frame % 8] = cl_port_a;
            hdr_b[fval_rise % 8][line_in_frame % 8] = cl_port_b;
            hdr_c[fval_rise % 8][line_in_frame % 8] = cl_port_c;
            line_in_frame++;
         end else if (cl_lval) begin
            dut_pix++;
         end
         if (cl_lval && dut_pix < 512) begin
            cap_a[dut_pix] = cl_port_a;
            cap_j[dut_pix] = cl_port_j;
         end
         prev_lval = cl_lval;
         prev_fval = cl_fval;
         if (pc_msg_ack) model_msg(cur_msg);
      end
   end

   task automatic send(input logic [11:0] op, input logic [19:0] arg);
      bit got;
      @(negedge bus_clk);
      cur_msg        = {op, arg};
      pc_msg         = cur_msg;
      pc_msg_pending = 1'b1;
      got            = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge bus_clk);
         if (pc_msg_ack) got = 1'b1;
      end
      pc_msg_pending = 1'b0;
      $display("msg op=%h arg=%0d acked=%0d t=%0t", op, arg, got, $time);
      chk("ack_seen", int'(got), 1);
      @(negedge bus_clk);
      chk("ack_one_cycle", int'(pc_msg_ack), 0);
   endtask

   task automatic wait_idle();
      @(negedge bus_clk);
      for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge bus_clk);
      chk("idle_reached", exp_q.size(), 0);
      repeat (2) @(negedge bus_clk);
   endtask

   initial begin : stim
      int b_fh, b_lh, b_lr, b_fr, b_gd;
      bit seen;

      // reset state
      repeat (3) @(negedge bus_clk);
      chk("rst_fval", int'(cl_fval), 0);
      chk("rst_lval", int'(cl_lval), 0);
      chk("rst_port_j", int'(cl_port_j), 0);
      chk("rst_ack", int'(pc_msg_ack), 0);
      chk("rst_done", int'(gen_done), 0);
      @(posedge bus_clk); #2 reset_n = 1'b1;
      repeat (2) @(negedge bus_clk);

      // 3 lines x 8 clocks, one frame
      send(12'h002, 20'd3);
      send(12'h003, 20'd8);
      b_fh = fval_hi; b_lh = lval_hi; b_lr = lval_rise; b_gd = gd_cnt; b_fr = fval_rise;
      send(12'h001, 20'd1);
      wait_idle();
      chk("f1_fval_cycles", fval_hi - b_fh, 34);
      chk("f1_lval_cycles", lval_hi - b_lh, 24);
      chk("f1_lval_pulses", lval_rise - b_lr, 3);
      chk("f1_frames", fval_rise - b_fr, 1);
      chk("f1_gen_done", gd_cnt - b_gd, 1);

      // zero-frame start
      b_fr = fval_rise; b_gd = gd_cnt;
      send(12'h001, 20'd0);
      wait_idle();
      chk("z_frames", fval_rise - b_fr, 0);
      chk("z_gen_done", gd_cnt - b_gd, 1);

      // 300-clock line: byte wrap
      send(12'h002, 20'd1);
      send(12'h003, 20'd300);
      send(12'h001, 20'd1);
      wait_idle();
      chk("wrap_a_255", int'(cap_a[255]), 255);
      chk("wrap_a_256", int'(cap_a[256]), 0);
      chk("wrap_a_299", int'(cap_a[299]), 43);
      chk("wrap_j_0", int'(cap_j[0]), 9);
      chk("wrap_a_0", int'(cap_a[0]), 0);
      chk("wrap_j_299", int'(cap_j[299]), 52);

      // 5-frame burst, dropped config, abort in 2nd line of frame 2, restart
      send(12'h002, 20'd3);
      send(12'h003, 20'd8);
      b_fr = fval_rise; b_gd = gd_cnt;
      send(12'h001, 20'd5);
      send(12'h003, 20'd2);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge bus_clk);
         if ((fval_rise - b_fr) == 2 && line_in_frame == 2) seen = 1'b1;
      end
      chk("abort_point_reached", int'(seen), 1);
      send(12'h00F, 20'd0);
      chk("abort_fval", int'(cl_fval), 0);
      chk("abort_lval", int'(cl_lval), 0);
      repeat (40) @(negedge bus_clk);
      chk("abort_frames", fval_rise - b_fr, 2);
      chk("abort_no_done", gd_cnt - b_gd, 0);
      send(12'h001, 20'd2);
      wait_idle();
      chk("restart_frames", fval_rise - b_fr, 4);
      chk("restart_done", gd_cnt - b_gd, 1);

      // abort and unknown opcode in IDLE are acked only
      b_gd = gd_cnt;
      send(12'h00F, 20'd0);
      send(12'h007, 20'd5);
      repeat (4) @(negedge bus_clk);
      chk("idle_cmds_no_done", gd_cnt - b_gd, 0);

      // reset in the middle of a line
      send(12'h003, 20'd300);
      send(12'h002, 20'd1);
      send(12'h001, 20'd3);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge bus_clk);
         if (cl_lval) seen = 1'b1;
      end
      chk("mid_line_reached", int'(seen), 1);
      repeat (5) @(posedge bus_clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_fval", int'(cl_fval), 0);
      chk("async_lval", int'(cl_lval), 0);
      chk("async_port_a", int'(cl_port_a), 0);
      chk("async_port_j", int'(cl_port_j), 0);
      repeat (2) @(posedge bus_clk);
      #2 reset_n = 1'b1;
      repeat (2) @(negedge bus_clk);
      b_lh = lval_hi; b_fh = fval_hi;
      send(12'h001, 20'd1);
      wait_idle();
      chk("post_rst_lval_cycles", lval_hi - b_lh, 1);
      chk("post_rst_fval_cycles", fval_hi - b_fh, 3);

`ifdef CL_GEN_HEADER_EN
      // header on pixel 0: 2 frames of 2 lines
      send(12'h002, 20'd2);
      send(12'h003, 20'd4);
      b_fr = fval_rise;
      send(12'h001, 20'd2);
      wait_idle();
      chk("hdr_a_f1l1", int'(hdr_a[(b_fr + 2) % 8][1]), 1);
      chk("hdr_b_f1l1", int'(hdr_b[(b_fr + 2) % 8][1]), 1);
      chk("hdr_c_f1l1", int'(hdr_c[(b_fr + 2) % 8][1]), 0);
      chk("hdr_a_f0l1", int'(hdr_a[(b_fr + 1) % 8][1]), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
